// File: rtl/gcd_pkg.sv
// gcd_pkg: shared types for the GCD engine.
//   state_t     - engine FSM states
//   MODE_EUCLID - subtractive Euclid reduction
//   MODE_STEIN  - binary (Stein) reduction
package gcd_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SUB    = 3'd1,
    SHIFT  = 3'd2,
    REDUCE = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic MODE_EUCLID = 1'b0;
  localparam logic MODE_STEIN  = 1'b1;

endpackage

// File: rtl/gcd_step.sv
// gcd_step: purely combinational single-step reduction for the GCD engine.
// Ports:
//   state      - current engine state (only SUB/SHIFT/REDUCE do anything)
//   a, b, k    - current working operands and common power-of-two count
//   a_nxt/b_nxt/k_nxt - operand values after this step
//   finish     - this step terminates the computation
//   strip_done - SHIFT has no more common factors of two to strip
//   result     - final gcd, meaningful when finish is high
module gcd_step
  import gcd_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int K_W   = 5
) (
  input  state_t           state,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [K_W-1:0]   k,
  output logic [WIDTH-1:0] a_nxt,
  output logic [WIDTH-1:0] b_nxt,
  output logic [K_W-1:0]   k_nxt,
  output logic             finish,
  output logic             strip_done,
  output logic [WIDTH-1:0] result
);

  logic [WIDTH-1:0] a_minus_b;
  logic [WIDTH-1:0] b_minus_a;

  // Only the difference selected by the a>b compare is ever used, so the
  // chosen one never underflows.
  assign a_minus_b = a - b;
  assign b_minus_a = b - a;

  always_comb begin
    a_nxt      = a;
    b_nxt      = b;
    k_nxt      = k;
    finish     = 1'b0;
    strip_done = 1'b0;
    result     = a;
    case (state)
      SUB: begin
        if (a == b)     finish = 1'b1;
        else if (a > b) a_nxt  = a_minus_b;
        else            b_nxt  = b_minus_a;
      end
      SHIFT: begin
        if (!a[0] && !b[0]) begin
          a_nxt = a >> 1;
          b_nxt = b >> 1;
          k_nxt = k + 1'b1;
        end else begin
          strip_done = 1'b1;
        end
      end
      REDUCE: begin
        if (!a[0])          a_nxt = a >> 1;
        else if (!b[0])     b_nxt = b >> 1;
        else if (a == b) begin
          finish = 1'b1;
          // k never exceeds the trailing zeros stripped, so this cannot overflow.
          result = a << k;
        end
        else if (a > b)     a_nxt = a_minus_b >> 1;
        else                b_nxt = b_minus_a >> 1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/gcd_engine.sv
// gcd_engine: handshaked GCD engine, Euclid or Stein selectable per request.
// Ports:
//   clk, rst                  - clock, async active-high reset
//   in_valid/in_ready         - request handshake (ready only in IDLE)
//   in_a, in_b, in_mode       - operands and mode, sampled on accept
//   out_valid/out_ready       - result handshake, result held until taken
//   out_gcd, out_cycles       - result and saturating compute-cycle count
//   busy                      - engine is not in IDLE
//
// state  | meaning
// IDLE   | waiting for a request
// SUB    | Euclid subtractive step
// SHIFT  | Stein: stripping common factors of two
// REDUCE | Stein: binary reduction
// DONE   | result presented, waiting for out_ready
module gcd_engine
  import gcd_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_gcd,
  output logic [CNT_W-1:0] out_cycles,
  output logic             busy
);

  localparam int K_W = $clog2(WIDTH + 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q, a_d, b_d;
  logic [WIDTH-1:0] gcd_q, gcd_d;
  logic [K_W-1:0]   k_q, k_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;

  logic [WIDTH-1:0] a_s, b_s, result;
  logic [K_W-1:0]   k_s;
  logic             finish, strip_done;
  logic             accept;

  gcd_step #(.WIDTH(WIDTH), .K_W(K_W)) u_step (
    .state      (state),
    .a          (a_q),
    .b          (b_q),
    .k          (k_q),
    .a_nxt      (a_s),
    .b_nxt      (b_s),
    .k_nxt      (k_s),
    .finish     (finish),
    .strip_done (strip_done),
    .result     (result)
  );

  // Held low while reset is asserted so no request appears accepted then.
  assign in_ready   = (state == IDLE) && !rst;
  assign accept     = in_valid && in_ready;
  assign busy       = (state != IDLE);
  assign out_valid  = (state == DONE);
  assign out_gcd    = gcd_q;
  assign out_cycles = cyc_q;

  always_comb begin
    state_nxt = state;
    a_d       = a_q;
    b_d       = b_q;
    k_d       = k_q;
    cyc_d     = cyc_q;
    gcd_d     = gcd_q;
    case (state)
      IDLE: begin
        if (accept) begin
          a_d   = in_a;
          b_d   = in_b;
          k_d   = '0;
          cyc_d = '0;
          // The mode is carried by the state choice itself; no register needed.
          if (in_a == '0 || in_b == '0) begin
            gcd_d     = in_a | in_b;
            state_nxt = DONE;
          end else begin
            state_nxt = (in_mode == MODE_STEIN) ? SHIFT : SUB;
          end
        end
      end
      SUB, SHIFT, REDUCE: begin
        a_d   = a_s;
        b_d   = b_s;
        k_d   = k_s;
        cyc_d = (&cyc_q) ? cyc_q : cyc_q + 1'b1;
        if (finish) begin
          gcd_d     = result;
          state_nxt = DONE;
        end else if (state == SHIFT && strip_done) begin
          state_nxt = REDUCE;
        end
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      k_q   <= '0;
      cyc_q <= '0;
      gcd_q <= '0;
    end else begin
      state <= state_nxt;
      a_q   <= a_d;
      b_q   <= b_d;
      k_q   <= k_d;
      cyc_q <= cyc_d;
      gcd_q <= gcd_d;
    end
  end

endmodule

// File: tb/tb_gcd_engine.sv
// tb_gcd_engine: self-checking bench for gcd_engine.
// Two instances: 16-bit/16-bit counter, and 8-bit with a 4-bit counter for
// saturation and narrow random runs. sel picks which instance is driven/observed.
module tb_gcd_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        sel;
  logic        in_valid;
  logic [15:0] in_a, in_b;
  logic        in_mode;
  logic        out_ready;

  logic        rdy16, ov16, busy16;
  logic [15:0] g16, c16;
  logic        rdy8, ov8, busy8;
  logic [7:0]  g8;
  logic [3:0]  c8;

  logic        o_rdy, o_valid, o_busy;
  logic [15:0] o_gcd, o_cyc;

  gcd_engine #(.WIDTH(16), .CNT_W(16)) dut16 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid && !sel), .in_ready(rdy16),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode),
    .out_valid(ov16), .out_ready(out_ready && !sel),
    .out_gcd(g16), .out_cycles(c16), .busy(busy16)
  );

  gcd_engine #(.WIDTH(8), .CNT_W(4)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid && sel), .in_ready(rdy8),
    .in_a(in_a[7:0]), .in_b(in_b[7:0]), .in_mode(in_mode),
    .out_valid(ov8), .out_ready(out_ready && sel),
    .out_gcd(g8), .out_cycles(c8), .busy(busy8)
  );

  assign o_rdy   = sel ? rdy8  : rdy16;
  assign o_valid = sel ? ov8   : ov16;
  assign o_busy  = sel ? busy8 : busy16;
  assign o_gcd   = sel ? {8'd0, g8}  : g16;
  assign o_cyc   = sel ? {12'd0, c8} : c16;

  int n_chk  = 0;
  int n_pass = 0;
  logic [15:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
  endtask

  task automatic finish_up();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  endtask

  function automatic logic [15:0] sw_gcd(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic mode);
    int t;
    t = 0;
    while (!o_rdy && t < 100) begin
      tick();
      t++;
    end
    if (!o_rdy) begin
      chk("ready_timeout", o_rdy, 1);
      finish_up();
    end
    in_a     = a;
    in_b     = b;
    in_mode  = mode;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_a     = 16'($urandom);
    in_b     = 16'($urandom);
    exp_q.push_back(sw_gcd(a, b));
  endtask

  task automatic wait_valid(input int lim, output int lat);
    lat = 1;
    while (!o_valid && lat < lim) begin
      tick();
      lat++;
    end
    if (!o_valid) begin
      chk("valid_timeout", o_valid, 1);
      finish_up();
    end
  endtask

  task automatic take_result(input string tag);
    logic [15:0] e;
    chk({tag, "_sb"}, exp_q.size() != 0, 1);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
    chk({tag, "_gcd"}, o_gcd, e);
    out_ready = 1'b1;
    tick();
  endtask

  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic mode, input int lim, output int lat, output int cyc);
    start_op(a, b, mode);
    wait_valid(lim, lat);
    cyc = int'(o_cyc);
    take_result(tag);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, cyc;
    logic [15:0] ra, rb;
    rst = 1'b0; sel = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
    in_mode = 1'b0; out_ready = 1'b1;

    #2 rst = 1'b1;
    #1;
    chk("rst_in_ready", o_rdy, 0);
    chk("rst_out_valid", o_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_gcd", o_gcd, 0);
    chk("rst_cycles", o_cyc, 0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_ready", o_rdy, 1);
    tick();

    run_op("euc_12_8", 16'd12, 16'd8, 1'b0, 10, lat, cyc);
    chk("euc_12_8_cyc", cyc, 3);
    chk("euc_12_8_lat", lat, 4);

    run_op("stein_12_8", 16'd12, 16'd8, 1'b1, 20, lat, cyc);
    chk("stein_12_8_cyc", cyc, 6);
    chk("stein_12_8_lat", lat, 7);

    run_op("stein_ffff_1", 16'hFFFF, 16'd1, 1'b1, 40, lat, cyc);
    chk("stein_ffff_bound", cyc <= 33, 1);

    for (int m = 0; m < 2; m++) begin
      run_op("zero_0_9", 16'd0, 16'd9, 1'(m), 5, lat, cyc);
      chk("zero_0_9_cyc", cyc, 0);
      chk("zero_0_9_lat", lat, 1);
      run_op("zero_7_0", 16'd7, 16'd0, 1'(m), 5, lat, cyc);
      chk("zero_7_0_cyc", cyc, 0);
      run_op("zero_0_0", 16'd0, 16'd0, 1'(m), 5, lat, cyc);
      chk("zero_0_0_cyc", cyc, 0);
    end

    // Back-pressure: Euclid (21,14) finishes in 3 cycles with gcd 7.
    out_ready = 1'b0;
    start_op(16'd21, 16'd14, 1'b0);
    wait_valid(10, lat);
    for (int i = 0; i < 20; i++) begin
      in_valid = (i % 2 == 0);
      in_a     = 16'($urandom);
      in_b     = 16'($urandom);
      tick();
      chk("bp_valid", o_valid, 1);
      chk("bp_gcd", o_gcd, 7);
      chk("bp_cyc", o_cyc, 3);
      chk("bp_in_ready", o_rdy, 0);
    end
    in_valid = 1'b0;
    take_result("bp");
    chk("bp_release_ready", o_rdy, 1);
    chk("bp_release_valid", o_valid, 0);

    // Async reset in the middle of a long Euclid run.
    start_op(16'hFFFF, 16'd1, 1'b0);
    repeat (50) tick();
    chk("mid_busy", o_busy, 1);
    chk("mid_cyc", o_cyc, 50);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", o_valid, 0);
    chk("arst_busy", o_busy, 0);
    chk("arst_gcd", o_gcd, 0);
    chk("arst_cyc", o_cyc, 0);
    chk("arst_ready", o_rdy, 0);
    exp_q.delete();
    tick();
    rst = 1'b0;
    tick();
    chk("arst_idle_ready", o_rdy, 1);
    run_op("after_rst", 16'd21, 16'd14, 1'b0, 10, lat, cyc);

    // Counter saturation on the 4-bit-counter instance.
    sel = 1'b1;
    tick();
    run_op("sat_200_1", 16'd200, 16'd1, 1'b0, 210, lat, cyc);
    chk("sat_cyc", cyc, 15);

    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 200; i++) begin
        ra = 16'($urandom_range(0, 255));
        rb = 16'($urandom_range(0, 255));
        run_op("rnd8", ra, rb, 1'(m), 260, lat, cyc);
      end
    end

    sel = 1'b0;
    tick();
    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom_range(0, 3000));
      rb = 16'($urandom_range(0, 3000));
      run_op("rnd16_euc", ra, rb, 1'b0, 3010, lat, cyc);
      chk("rnd16_euc_lat", lat, cyc + 1);
    end
    for (int i = 0; i < 100; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      run_op("rnd16_stein", ra, rb, 1'b1, 40, lat, cyc);
      chk("rnd16_stein_bound", cyc <= 33, 1);
      chk("rnd16_stein_lat", lat, cyc + 1);
    end

    finish_up();
  end

endmodule
